fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 137 +++++++++++++
 tb/tb_fifo_wr_arb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Purpose: round-robin arbiter that lets one requester at a time burst beats into a FIFO write port.
// Latency: one IDLE cycle to pick a requester; beats then pass combinationally (reqData -> dataIn) at one per cycle.
// Backpressure: FULL stalls the granted requester (reqReady/WR low) with grant and beat count held.
//
// Ports:
//   Clk, Rst          - clock; asynchronous active-high reset
//   reqValid/reqData  - per-requester beat offer and data (requester i owns reqData[i*DATA_WIDTH +: DATA_WIDTH])
//   reqReady          - per-requester accept, only ever set for the granted requester
//   FULL              - FIFO full flag
//   WR/dataIn         - FIFO write strobe and data
//   grantId, busy     - granted requester index; high while a grant is open
module fifo_wr_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [NUM_REQ-1:0]              reqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   reqData,
  output logic [NUM_REQ-1:0]              reqReady,
  input  logic                            FULL,
  output logic                            WR,
  output logic [DATA_WIDTH-1:0]           dataIn,
  output logic [$clog2(NUM_REQ)-1:0]      grantId,
  output logic                            busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  BURST_LAST = CW'(MAX_BURST);
  localparam logic [IDW-1:0] LAST_REQ   = IDW'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

  // Round-robin pick: lowest valid index at/above rr_ptr_q wins; if none,
  // wrap to the lowest valid index overall.
  logic           found_hi;
  logic [IDW-1:0] pick_hi, pick_lo, pick;

  always_comb begin
    found_hi = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (reqValid[i]) begin
        pick_lo = IDW'(i);
        if (IDW'(i) >= rr_ptr_q) begin
          found_hi = 1'b1;
          pick_hi  = IDW'(i);
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  logic           vld_g;
  logic           xfer;
  logic [CW-1:0]  beat_inc;
  logic [IDW-1:0] next_ptr;

  assign vld_g    = reqValid[grant_q];
  assign xfer     = (state_q == GRANT) && vld_g && !FULL;
  assign beat_inc = beat_cnt_q + CW'(1);
  assign next_ptr = (grant_q == LAST_REQ) ? '0 : grant_q + IDW'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|reqValid) begin
          grant_d    = pick;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // A dropped valid ends the grant even while FULL is stalling it.
        if (!vld_g) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (xfer) begin
          beat_cnt_d = beat_inc;
          if (beat_inc == BURST_LAST) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Outputs decode straight from state, so reset clears them without a clock.
  always_comb begin
    reqReady = '0;
    WR       = 1'b0;
    busy     = 1'b0;
    if (state_q == GRANT) begin
      busy              = 1'b1;
      reqReady[grant_q] = !FULL;
      WR                = vld_g && !FULL;
    end
  end

  always_comb begin
    dataIn = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDW'(i)) dataIn = reqData[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grantId = grant_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Purpose: directed bench for fifo_wr_arb (DATA_WIDTH=8, NUM_REQ=4, MAX_BURST=4).
// Latency: inputs are driven 1 time unit after each rising edge and outputs are sampled 1 unit later.
// Backpressure: FULL is driven directly by the stimulus sequence.
module tb_fifo_wr_arb;

  logic        Clk;
  logic        Rst;
  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic [3:0]  reqReady;
  logic        FULL;
  logic        WR;
  logic [7:0]  dataIn;
  logic [1:0]  grantId;
  logic        busy;

  int vectors;
  int miscompares;
  logic [7:0] d [4];

  fifo_wr_arb #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .reqValid (reqValid),
    .reqData  (reqData),
    .reqReady (reqReady),
    .FULL     (FULL),
    .WR       (WR),
    .dataIn   (dataIn),
    .grantId  (grantId),
    .busy     (busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_busy, input logic [31:0] e_wr,
                         input logic [31:0] e_rdy, input logic [31:0] e_gid);
    chk({tag, ".busy"},     32'(busy),     e_busy);
    chk({tag, ".WR"},       32'(WR),       e_wr);
    chk({tag, ".reqReady"}, 32'(reqReady), e_rdy);
    chk({tag, ".grantId"},  32'(grantId),  e_gid);
  endtask

  task automatic apply_data();
    for (int i = 0; i < 4; i++) reqData[i*8 +: 8] = d[i];
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Clk         = 1'b0;
    Rst         = 1'b1;
    FULL        = 1'b0;
    reqValid    = 4'b0000;
    for (int i = 0; i < 4; i++) d[i] = 8'(i * 16);
    apply_data();

    // Reset state
    #2;
    chk_out("reset", 0, 0, 0, 0);
    tick();
    Rst = 1'b0;
    #1;
    chk_out("post_reset", 0, 0, 0, 0);

    // Single requester 2 with 6 beats: 4-beat burst, one IDLE cycle, 2 more beats
    reqValid = 4'b0100;
    #1;
    chk_out("t1_idle", 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_out("t1_beat", 1, 1, 32'b0100, 2);
      chk("t1_data", 32'(dataIn), 32'h20 + 32'(k));
      tick();
      d[2] = d[2] + 8'd1;
      apply_data();
    end
    #1;
    chk_out("t1_gap", 0, 0, 0, 2);
    tick();
    for (int k = 4; k < 6; k++) begin
      #1;
      chk_out("t1_beat2", 1, 1, 32'b0100, 2);
      chk("t1_data2", 32'(dataIn), 32'h20 + 32'(k));
      tick();
      d[2] = d[2] + 8'd1;
      apply_data();
    end
    reqValid = 4'b0000;
    #1;
    chk_out("t1_drop", 1, 0, 32'b0100, 2);
    tick();
    #1;
    chk_out("t1_end", 0, 0, 0, 2);

    // All four requesting: order 0,1,2,3,0 with 4 beats then one IDLE cycle each
    Rst = 1'b1;
    #1;
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 8'(i * 16);
    apply_data();
    reqValid = 4'b1111;
    #1;
    chk_out("t2_idle", 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 4; k++) begin
        #1;
        chk_out("t2_beat", 1, 1, 32'(1) << (n % 4), 32'(n % 4));
        chk("t2_data", 32'(dataIn), 32'((n % 4) * 16));
        tick();
      end
      #1;
      chk_out("t2_gap", 0, 0, 0, 32'(n % 4));
      if (n == 4) reqValid = 4'b0000;
      tick();
    end

    // Backpressure: FULL for 3 cycles after beat 2 of a grant to requester 1
    reqValid = 4'b0010;
    #1;
    chk_out("t3_idle", 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk_out("t3_beat_a", 1, 1, 32'b0010, 1);
      tick();
    end
    FULL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_out("t3_full", 1, 0, 0, 1);
      tick();
    end
    FULL = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk_out("t3_beat_b", 1, 1, 32'b0010, 1);
      tick();
    end
    #1;
    chk_out("t3_done", 0, 0, 0, 1);

    // Early release: requester 1 drops after 2 beats, requester 3 raised mid-grant
    tick();
    reqValid = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk_out("t4_beat", 1, 1, 32'b0010, 1);
      tick();
    end
    reqValid = 4'b1000;
    #1;
    chk_out("t4_drop", 1, 0, 32'b0010, 1);
    tick();
    #1;
    chk_out("t4_idle", 0, 0, 0, 1);
    tick();
    #1;
    chk_out("t4_grant3", 1, 1, 32'b1000, 3);
    chk("t4_data", 32'(dataIn), 32'h30);

    // Reset after beat 1 of the grant to requester 3
    tick();
    #1;
    chk_out("t5_beat2", 1, 1, 32'b1000, 3);
    Rst = 1'b1;
    #1;
    chk_out("t5_async", 0, 0, 0, 0);
    reqValid = 4'b1010;
    tick();
    #1;
    chk_out("t5_held", 0, 0, 0, 0);
    Rst = 1'b0;
    #1;
    chk_out("t5_idle", 0, 0, 0, 0);
    tick();
    #1;
    chk_out("t5_regrant", 1, 1, 32'b0010, 1);
    chk("t5_data", 32'(dataIn), 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
